// File: rtl/alu_muldiv_if.sv
// Request/response bundle between the execute-stage controller and alu_muldiv.
// The controller drives the master side; the ALU implements the slave side.
interface alu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alucont;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zf;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;

    modport master (
        output in_valid, a, b, alucont,
        input  in_ready, out_valid, result, zf, hi, lo, busy
    );

    modport slave (
        input  in_valid, a, b, alucont,
        output in_ready, out_valid, result, zf, hi, lo, busy
    );
endinterface

// File: rtl/alu_muldiv.sv
// alu_muldiv: registered MIPS ALU with valid/ready handshake and HI/LO registers.
// Define ALU_MULDIV_EN to build the iterative multiply/divide unit (ops 1100-1111).
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic        clk,
    input  logic        reset_n,
    alu_muldiv_if.slave bus
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;

    logic             accept;
    logic             start_muldiv;
    logic             finish;
    logic             zf_done;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] result_q;
    logic             zf_q;
    logic             out_valid_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign shamt  = bus.a[SHW-1:0];

    always_comb begin
        alu_out = '0;
        case (bus.alucont)
            OP_AND:  alu_out = bus.a & bus.b;
            OP_OR:   alu_out = bus.a | bus.b;
            OP_ADD:  alu_out = bus.a + bus.b;
            OP_XOR:  alu_out = bus.a ^ bus.b;
            OP_NOR:  alu_out = ~(bus.a | bus.b);
            OP_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_SUB:  alu_out = bus.a - bus.b;
            OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLL:  alu_out = bus.b << shamt;
            OP_SRL:  alu_out = bus.b >> shamt;
            OP_SRA:  alu_out = $signed(bus.b) >>> shamt;
            default: alu_out = '0;
        endcase
    end

    // Single-cycle ops update result/zf at accept; a finishing mul/div only presents its zf.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_q    <= '0;
            zf_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (accept && !start_muldiv) begin
                result_q    <= alu_out;
                zf_q        <= (bus.a == bus.b);
                out_valid_q <= 1'b1;
            end else if (finish) begin
                zf_q        <= zf_done;
                out_valid_q <= 1'b1;
            end
        end
    end

    assign bus.result    = result_q;
    assign bus.zf        = zf_q;
    assign bus.out_valid = out_valid_q;

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [SHW:0]       cnt;
    logic [WIDTH:0]     acc;
    logic [WIDTH:0]     acc_next;
    logic [WIDTH-1:0]   sh;
    logic [WIDTH-1:0]   sh_next;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               dbz;
    logic               zf_pend;
    logic               op_signed;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               iterating;
    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   hi_next;
    logic [WIDTH-1:0]   lo_next;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    assign op_signed    = !bus.alucont[0];
    assign sign_a       = op_signed && bus.a[WIDTH-1];
    assign sign_b       = op_signed && bus.b[WIDTH-1];
    assign mag_a        = sign_a ? -bus.a : bus.a;
    assign mag_b        = sign_b ? -bus.b : bus.b;
    assign start_muldiv = accept && (bus.alucont[3:2] == 2'b11);
    assign iterating    = (state == MUL) || (state == DIV);
    assign finish       = iterating && (cnt == (SHW+1)'(WIDTH - 1));
    assign zf_done      = zf_pend;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start_muldiv) state_next = bus.alucont[1] ? DIV : MUL;
            MUL, DIV: if (finish) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // acc/sh form one shift register: {upper partial product, multiplier} or {remainder, quotient}.
    always_comb begin
        mul_sum   = acc + (sh[0] ? {1'b0, divisor} : '0);
        div_shift = {acc[WIDTH-1:0], sh[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, divisor};
        acc_next  = acc;
        sh_next   = sh;
        if (state == MUL) begin
            acc_next = {1'b0, mul_sum[WIDTH:1]};
            sh_next  = {mul_sum[0], sh[WIDTH-1:1]};
        end else if (state == DIV) begin
            if (!div_diff[WIDTH+1]) begin
                acc_next = div_diff[WIDTH:0];
                sh_next  = {sh[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = div_shift;
                sh_next  = {sh[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Signs are restored on the final step so HI/LO are valid together with out_valid.
    always_comb begin
        prod_raw = {acc_next[WIDTH-1:0], sh_next};
        prod_fix = neg_q ? -prod_raw : prod_raw;
        quot_fix = dbz ? '1 : (neg_q ? -sh_next : sh_next);
        rem_fix  = neg_r ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
        hi_next  = is_div ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
        lo_next  = is_div ? quot_fix : prod_fix[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            acc     <= '0;
            sh      <= '0;
            divisor <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dbz     <= 1'b0;
            zf_pend <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (start_muldiv) begin
            cnt     <= '0;
            acc     <= '0;
            sh      <= mag_a;
            divisor <= mag_b;
            is_div  <= bus.alucont[1];
            neg_q   <= sign_a ^ sign_b;
            neg_r   <= sign_a;
            dbz     <= bus.alucont[1] && (bus.b == '0);
            zf_pend <= (bus.a == bus.b);
        end else if (iterating) begin
            cnt <= cnt + 1'b1;
            acc <= acc_next;
            sh  <= sh_next;
            if (finish) begin
                hi_q <= hi_next;
                lo_q <= lo_next;
            end
        end
    end

    assign bus.in_ready = (state == IDLE);
    assign bus.busy     = iterating;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
`else
    assign start_muldiv = 1'b0;
    assign finish       = 1'b0;
    assign zf_done      = 1'b0;
    assign bus.in_ready = 1'b1;
    assign bus.busy     = 1'b0;
    assign bus.hi       = '0;
    assign bus.lo       = '0;
`endif

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed vectors against a behavioural model.
// Define ALU_MULDIV_EN for both bench and RTL to exercise the multiply/divide unit.
module tb_alu_muldiv;

    localparam int W = 32;
`ifdef ALU_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MULT = 4'b1100;
    localparam logic [3:0] OP_MULU = 4'b1101;
    localparam logic [3:0] OP_DIV  = 4'b1110;
    localparam logic [3:0] OP_DIVU = 4'b1111;

    typedef struct {
        int           due;
        bit           upd_res;
        logic [W-1:0] res;
        logic         zf;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;

    alu_muldiv_if #(.WIDTH(W)) bus ();

    alu_muldiv #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           ready_from = 0;
    int           busy_end = 0;
    int           last_due = 0;
    bit           last_accept = 1'b0;
    bit           run_checks = 1'b0;
    exp_t         pend[$];
    logic [W-1:0] m_result = '0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         m_zf = 1'b0;
    int           low_cnt;

    task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pin(input string name, input logic [W-1:0] dut_v, input logic [W-1:0] model_v,
                       input logic [W-1:0] lit);
        check_output(name, dut_v, lit);
        check_output({name, "_model"}, model_v, lit);
    endtask

    function automatic void model_reset();
        pend.delete();
        m_result   = '0;
        m_hi       = '0;
        m_lo       = '0;
        m_zf       = 1'b0;
        ready_from = cyc;
        busy_end   = 0;
        last_due   = cyc;
    endfunction

    // Architectural view of one accepted operation; cyc is the first cycle after the accept edge.
    function automatic void model_accept(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t            e;
        longint          sa, sb, sp, q, r;
        longint unsigned up;
        e.due     = cyc;
        e.upd_res = 1'b1;
        e.res     = '0;
        e.zf      = (a == b);
        e.hi      = '0;
        e.lo      = '0;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            OP_AND:  e.res = a & b;
            OP_OR:   e.res = a | b;
            OP_ADD:  e.res = a + b;
            OP_XOR:  e.res = a ^ b;
            OP_NOR:  e.res = ~(a | b);
            OP_SLTU: e.res = (a < b) ? 32'd1 : 32'd0;
            OP_SUB:  e.res = a - b;
            OP_SLT:  e.res = (sa < sb) ? 32'd1 : 32'd0;
            OP_SLL:  e.res = b << a[4:0];
            OP_SRL:  e.res = b >> a[4:0];
            OP_SRA:  e.res = $signed(b) >>> a[4:0];
            default: e.res = '0;
        endcase
        if (MD_EN && op[3:2] == 2'b11) begin
            e.upd_res  = 1'b0;
            e.due      = cyc + W;
            busy_end   = cyc + W;
            ready_from = cyc + W + 1;
            case (op)
                OP_MULT: begin
                    sp   = sa * sb;
                    e.hi = sp[63:32];
                    e.lo = sp[31:0];
                end
                OP_MULU: begin
                    up   = 64'(a) * 64'(b);
                    e.hi = up[63:32];
                    e.lo = up[31:0];
                end
                OP_DIV: begin
                    if (b == '0) begin
                        e.hi = a;
                        e.lo = '1;
                    end else begin
                        q    = sa / sb;
                        r    = sa % sb;
                        e.hi = r[31:0];
                        e.lo = q[31:0];
                    end
                end
                default: begin
                    if (b == '0) begin
                        e.hi = a;
                        e.lo = '1;
                    end else begin
                        e.hi = a % b;
                        e.lo = a / b;
                    end
                end
            endcase
        end
        last_due = e.due;
        pend.push_back(e);
    endfunction

    // Every cycle out of reset: handshake, busy and all held registers against the model.
    always @(negedge clk) begin
        exp_t e;
        bit   exp_ov;
        if (reset_n && run_checks) begin
            exp_ov = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                e      = pend.pop_front();
                exp_ov = 1'b1;
                m_zf   = e.zf;
                if (e.upd_res) begin
                    m_result = e.res;
                end else begin
                    m_hi = e.hi;
                    m_lo = e.lo;
                end
            end
            check_output("out_valid", bus.out_valid, exp_ov);
            check_output("in_ready", bus.in_ready, (cyc >= ready_from));
            check_output("busy", bus.busy, (cyc < busy_end));
            check_output("result", bus.result, m_result);
            check_output("zf", bus.zf, m_zf);
            check_output("hi", bus.hi, m_hi);
            check_output("lo", bus.lo, m_lo);
        end
    end

    task automatic tick();
        bit take;
        take = reset_n && bus.in_valid && (cyc >= ready_from);
        @(posedge clk);
        cyc++;
        last_accept = take;
        if (take) model_accept(bus.alucont, bus.a, bus.b);
        #1;
    endtask

    task automatic apply_stimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        bus.alucont  = op;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        last_accept  = 1'b0;
        while (!last_accept && n < 100) begin
            tick();
            n++;
        end
        check_output("accept", last_accept, 1'b1);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lows);
        int n;
        n    = 0;
        lows = bus.in_ready ? 0 : 1;
        while ((cyc < last_due || cyc < ready_from) && n < 200) begin
            tick();
            n++;
            if (!bus.in_ready) lows++;
        end
        check_output("drain", (n < 200), 1'b1);
        @(negedge clk);
        #1;
    endtask

    logic [3:0]   t_op [6] = '{OP_XOR, OP_NOR, 4'b1011, OP_SRL, OP_AND, OP_SLL};
    logic [W-1:0] t_a  [6] = '{32'hA5A5_0F0F, 32'h0000_0001, 32'h1234_5678, 32'd31, 32'hFFFF_0000, 32'd8};
    logic [W-1:0] t_b  [6] = '{32'h5A5A_F0F0, 32'h8000_0000, 32'h1234_5678, 32'h8000_0000, 32'h00FF_FF00, 32'd1};

    initial begin
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.alucont  = '0;
        model_reset();
        #12;
        check_output("reset_out_valid", bus.out_valid, 1'b0);
        check_output("reset_in_ready", bus.in_ready, 1'b1);
        check_output("reset_busy", bus.busy, 1'b0);
        check_output("reset_result", bus.result, '0);
        check_output("reset_hi", bus.hi, '0);
        check_output("reset_lo", bus.lo, '0);
        @(negedge clk);
        reset_n    = 1'b1;
        run_checks = 1'b1;

        apply_stimulus(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        idle();
        wait_done(low_cnt);
        pin("add_ovf", bus.result, m_result, 32'h8000_0000);
        pin("add_zf", bus.zf, m_zf, 0);
        apply_stimulus(OP_SUB, 32'd5, 32'd5);
        idle();
        wait_done(low_cnt);
        pin("sub_eq", bus.result, m_result, 0);
        pin("sub_zf", bus.zf, m_zf, 1);

        apply_stimulus(OP_SLT, 32'hFFFF_FFFF, 32'd1);
        idle();
        wait_done(low_cnt);
        pin("slt_neg", bus.result, m_result, 1);
        apply_stimulus(OP_SLTU, 32'hFFFF_FFFF, 32'd1);
        idle();
        wait_done(low_cnt);
        pin("sltu_big", bus.result, m_result, 0);
        apply_stimulus(OP_SRA, 32'd4, 32'h8000_0000);
        idle();
        wait_done(low_cnt);
        pin("sra4", bus.result, m_result, 32'hF800_0000);

        for (int i = 0; i < 6; i++) apply_stimulus(t_op[i], t_a[i], t_b[i]);
        idle();
        wait_done(low_cnt);
        pin("sll8", bus.result, m_result, 32'h0000_0100);

        apply_stimulus(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        idle();
        wait_done(low_cnt);
`ifdef ALU_MULDIV_EN
        check_output("mult_ready_low_cycles", low_cnt, 33);
        pin("mult_hi", bus.hi, m_hi, 32'hFFFF_FFFF);
        pin("mult_lo", bus.lo, m_lo, 32'hFFFF_FFEB);
        pin("mult_result_held", bus.result, m_result, 32'h0000_0100);
`else
        check_output("mult_ready_low_cycles", low_cnt, 0);
        pin("mult_result", bus.result, m_result, 0);
        pin("mult_hi", bus.hi, m_hi, 0);
        pin("mult_lo", bus.lo, m_lo, 0);
`endif
        apply_stimulus(OP_MULU, 32'hFFFF_FFFF, 32'd2);
        idle();
        wait_done(low_cnt);
        apply_stimulus(OP_MULU, 32'd5, 32'd5);
        idle();
        wait_done(low_cnt);
        apply_stimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        idle();
        wait_done(low_cnt);
        apply_stimulus(OP_DIV, 32'hFFFF_FFFB, 32'd0);
        idle();
        wait_done(low_cnt);
        apply_stimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        idle();
        wait_done(low_cnt);
`ifdef ALU_MULDIV_EN
        pin("div_neg_lo", bus.lo, m_lo, 32'hFFFF_FFFD);
        pin("div_neg_hi", bus.hi, m_hi, 32'hFFFF_FFFF);
`endif
        apply_stimulus(OP_DIVU, 32'd100, 32'd0);
        idle();
        wait_done(low_cnt);
`ifdef ALU_MULDIV_EN
        pin("divu_zero_lo", bus.lo, m_lo, 32'hFFFF_FFFF);
        pin("divu_zero_hi", bus.hi, m_hi, 32'd100);
`endif

        apply_stimulus(OP_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        apply_stimulus(OP_OR, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        apply_stimulus(OP_ADD, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        idle();
        wait_done(low_cnt);
        pin("b2b_add", bus.result, m_result, 32'h00E0_100E);

        apply_stimulus(OP_DIVU, 32'd50, 32'd7);
        bus.alucont = OP_ADD;
        bus.a       = 32'd1;
        bus.b       = 32'd2;
        repeat (5) tick();
        idle();
        wait_done(low_cnt);
`ifdef ALU_MULDIV_EN
        pin("div_ignore_result", bus.result, m_result, 32'h00E0_100E);
        pin("divu_q", bus.lo, m_lo, 32'd7);
        pin("divu_r", bus.hi, m_hi, 32'd1);
`endif

        apply_stimulus(OP_MULU, 32'hFFFF_FFFF, 32'd3);
        idle();
        repeat (9) tick();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_output("abort_out_valid", bus.out_valid, 1'b0);
        check_output("abort_in_ready", bus.in_ready, 1'b1);
        check_output("abort_busy", bus.busy, 1'b0);
        check_output("abort_result", bus.result, '0);
        check_output("abort_zf", bus.zf, 1'b0);
        check_output("abort_hi", bus.hi, '0);
        check_output("abort_lo", bus.lo, '0);
        repeat (2) tick();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check_output("post_reset_in_ready", bus.in_ready, 1'b1);
        check_output("post_reset_hi", bus.hi, '0);
        check_output("post_reset_lo", bus.lo, '0);
        apply_stimulus(OP_ADD, 32'd1, 32'd2);
        idle();
        wait_done(low_cnt);
        pin("post_reset_add", bus.result, m_result, 32'd3);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 200000 time units");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised, sequential successor to the single-cycle ALU in the MIPS datapath.
- Adds a registered result path, valid/ready handshake, signed and unsigned compare, and an iterative multiply/divide unit with HI/LO registers.
- Sits in the execute stage; the controller stalls the pipeline while in_ready is low.

Parameters:
- WIDTH, 32, operand/result width; must be even and >= 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept an operation this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- alucont  input  4  operation select
- out_valid  output  1  one-cycle pulse: result/zf/hi/lo updated
- result  output  WIDTH  registered result
- zf  output  1  registered (a == b) of the accepted operation
- hi  output  WIDTH  HI register (product upper half / remainder)
- lo  output  WIDTH  LO register (product lower half / quotient)
- busy  output  1  multi-cycle operation in progress

Behaviour:
- Reset (async, reset_n=0): state=IDLE; result=0, zf=0, hi=0, lo=0, out_valid=0, busy=0, in_ready=1. Deassertion is synchronised externally.
- Accept: an operation is taken when in_valid && in_ready. in_ready = (state==IDLE). a, b and alucont are sampled only on accept.
- alucont encoding:
  - 0000 and; 0001 or; 0010 add (wraps, no trap); 0011 xor; 0100 nor; 0101 sltu (unsigned a<b -> 1 else 0).
  - 0110 sub (wraps); 0111 slt (signed two's-complement a<b).
  - 1000 sll, b << a[SHW-1:0]; 1001 srl, logical; 1010 sra, arithmetic.
  - 1100 mult (signed); 1101 multu; 1110 div (signed); 1111 divu.
  - 1011 and any disabled op: result=0, single-cycle.
- Single-cycle ops: result and zf registered on the edge after accept; out_valid=1 for exactly that cycle; hi/lo unchanged; state stays IDLE, so back-to-back accepts every cycle are legal.
- Mul/div ops: on accept, state -> MUL or DIV; busy=1, in_ready=0; result and zf are not updated.
  - Iterate one bit per cycle for WIDTH cycles (shift-add multiply, restoring divide), then state DONE for one cycle.
  - In DONE: hi/lo written, out_valid=1, busy=0, then state -> IDLE.
  - Total latency from accept to out_valid: WIDTH+1 cycles.
  - zf is registered at accept (a==b) and presented with out_valid.
- Signed mult/div: operate on magnitudes and fix signs in DONE.
  - Product: 2*WIDTH two's complement; hi = upper half, lo = lower half.
  - Quotient is truncated toward zero; remainder takes the sign of the dividend.
  - Most-negative / -1: lo = most-negative, hi = 0 (no trap).
- Divide by zero (b==0, div or divu): runs full latency; lo = all ones, hi = a. No exception.
- in_valid while busy is ignored; the requester holds its request until in_ready.
- reset_n low mid-operation aborts immediately; partial hi/lo are never written.
- result, hi and lo hold their values between updates.

Optional Feature:
- ALU_MULDIV_EN defined: ops 1100-1111 behave as above; MUL, DIV and DONE states plus the iteration datapath are present.
- ALU_MULDIV_EN undefined: ops 1100-1111 are treated as undefined (result=0, single-cycle). hi/lo are tied to 0, busy is tied to 0, in_ready is tied to 1, and no iteration logic is synthesised.

Test Plan:
- Reset, then add a=0x7FFFFFFF b=1 -> next cycle out_valid=1, result=0x80000000, zf=0. Then sub a=5 b=5 -> result=0, zf=1.
- slt a=0xFFFFFFFF b=1 -> result=1. sltu with the same operands -> result=0. sra b=0x80000000 a=4 -> result=0xF8000000.
- mult a=-3 b=7 -> in_ready low for 33 cycles; out_valid at cycle 33 after accept; hi=0xFFFFFFFF, lo=0xFFFFFFEB. multu a=0xFFFFFFFF b=2 -> hi=1, lo=0xFFFFFFFE.
- div a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=100 b=0 -> lo=0xFFFFFFFF, hi=100.
- Back-to-back and/or/add with in_valid held high -> three consecutive out_valid pulses with correct results. in_valid asserted during a divide -> ignored, no extra out_valid.
- Assert reset_n=0 at cycle 10 of a multu -> all outputs 0 asynchronously; after release, in_ready=1 and hi/lo=0. Build without ALU_MULDIV_EN: mult -> out_valid next cycle, result=0, hi=lo=0.
